regs_wr_arbiter: RTL

Write-port controller for the 32x32 MIPS register file. It shares the file's single write port (write_enable/write_addr/write_val) between four sources:
- the pipeline writeback stage
- the multi-cycle mul/div unit
- the debugger
- an internal clear sequencer that zeroes r1..r31 on debugger command

It sits between those sources and the register file, and its registered outputs drive the register file directly.

---
 rtl/regs_wr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regs_wr_arbiter.sv
// Write-port controller for the 32x32 register file: arbitrates writeback, mul/div,
// debugger and an internal clear sweep onto one registered write port.
module regs_wr_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [31:0]       wb_val,
    input  logic              md_req,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [31:0]       md_val,
    output logic              md_ack,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_val,
    output logic              dbg_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_val
);
    localparam int                DATA_W   = 32;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    typedef enum logic {SRC_MD, SRC_DBG} src_t;

    state_t            state, state_next;
    src_t              rr_last, rr_next;
    logic [ADDR_W-1:0] ptr, ptr_next;

    logic              sel_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_val;
    logic              md_grant, dbg_grant;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        rr_next    = rr_last;
        sel_vld    = 1'b0;
        sel_addr   = '0;
        sel_val    = '0;
        md_grant   = 1'b0;
        dbg_grant  = 1'b0;

        // Slot selection: writeback always wins, then the sweep, then md/dbg.
        if (wb_req) begin
            sel_vld  = 1'b1;
            sel_addr = wb_addr;
            sel_val  = wb_val;
        end else if (state == SWEEP) begin
            sel_vld  = 1'b1;
            sel_addr = ptr;
            sel_val  = '0;
        end else if (state == IDLE) begin
            if (md_req && (!dbg_req || rr_last == SRC_DBG)) begin
                md_grant = 1'b1;
                sel_vld  = 1'b1;
                sel_addr = md_addr;
                sel_val  = md_val;
                rr_next  = SRC_MD;
            end else if (dbg_req) begin
                dbg_grant = 1'b1;
                sel_vld   = 1'b1;
                sel_addr  = dbg_addr;
                sel_val   = dbg_val;
                rr_next   = SRC_DBG;
            end
        end

        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next = SWEEP;
                    ptr_next   = FIRST_REG;
                end
            end
            SWEEP: begin
                // A writeback cycle steals the slot, so the pointer holds.
                if (!wb_req) begin
                    if (ptr == LAST_REG) state_next = DONE;
                    else                 ptr_next   = ptr + ADDR_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign md_ack  = md_grant && !rst;
    assign dbg_ack = dbg_grant && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= FIRST_REG;
            rr_last      <= SRC_DBG;
            clr_busy     <= 1'b0;
            clr_done     <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_val    <= '0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            rr_last      <= rr_next;
            clr_busy     <= (state_next == SWEEP);
            clr_done     <= (state_next == DONE);
            // r0 is hardwired zero: the grant is consumed but nothing is written.
            write_enable <= sel_vld && (sel_addr != '0);
            if (sel_vld) begin
                write_addr <= sel_addr;
                write_val  <= sel_val;
            end
        end
    end
endmodule
